// File: rtl/otsu_sweep_ctrl_pkg.sv
// Shared constants and state encoding for the Otsu threshold sweep controller.
// Latency: n/a (declarations only); backpressure: n/a.
package otsu_pkg;

  localparam int NUM_BINS = 256;
  localparam int BIN_W    = 8;
  localparam int COUNT_W  = 32;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SWEEP,
    DRAIN,
    EVAL_REQ,
    EVAL_WAIT,
    DONE
  } state_t;

  function automatic logic is_busy_state(state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/otsu_sweep_ctrl_if.sv
// Bundles the controller's start/result, histogram, accumulator and evaluator signals.
// Latency: wires only; backpressure: evaluator stalls the controller by withholding score_valid.
interface otsu_sweep_ctrl_if #(
  parameter int SCORE_W = 64
);
  import otsu_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [BIN_W-1:0]     best_threshold;
  logic [SCORE_W-1:0]   best_score;

  logic                 hist_rd_en;
  logic [BIN_W-1:0]     hist_addr;
  logic [COUNT_W-1:0]   hist_data;

  logic                 acc_clear;
  logic                 acc_valid;
  logic [BIN_W-1:0]     acc_i;
  logic [COUNT_W-1:0]   acc_n_i;
  logic [BIN_W-1:0]     acc_threshold;

  logic                 eval_req;
  logic [BIN_W-1:0]     eval_threshold;
  logic                 score_valid;
  logic [SCORE_W-1:0]   score;

  modport master (
    input  start, hist_data, score_valid, score,
    output busy, done, best_threshold, best_score,
           hist_rd_en, hist_addr,
           acc_clear, acc_valid, acc_i, acc_n_i, acc_threshold,
           eval_req, eval_threshold
  );

  modport slave (
    output start, hist_data, score_valid, score,
    input  busy, done, best_threshold, best_score,
           hist_rd_en, hist_addr,
           acc_clear, acc_valid, acc_i, acc_n_i, acc_threshold,
           eval_req, eval_threshold
  );

endinterface

// File: rtl/otsu_best_tracker.sv
// Keeps the best (threshold, score) pair; the first threshold of a search always loads.
// Latency: 1 cycle from load_en to updated outputs; backpressure: none.
module otsu_best_tracker
  import otsu_pkg::*;
#(
  parameter int SCORE_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               first,
  input  logic [BIN_W-1:0]   threshold,
  input  logic [SCORE_W-1:0] score,
  output logic [BIN_W-1:0]   best_threshold,
  output logic [SCORE_W-1:0] best_score
);

  logic [BIN_W-1:0]   best_thr_q;
  logic [SCORE_W-1:0] best_score_q;

  // Strict compare: a tie never displaces the earlier (lower) threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_thr_q   <= '0;
      best_score_q <= '0;
    end else if (load_en && (first || (score > best_score_q))) begin
      best_thr_q   <= threshold;
      best_score_q <= score;
    end
  end

  assign best_threshold = best_thr_q;
  assign best_score     = best_score_q;

endmodule

// File: rtl/otsu_sweep_ctrl.sv
// Sweeps all 256 thresholds: clear accumulators, stream the histogram, request a score, track the best.
// Latency: 261 cycles per threshold at ACC_LAT=1 with a 1-cycle evaluator; backpressure: waits indefinitely for score_valid.
module otsu_sweep_ctrl
  import otsu_pkg::*;
#(
  parameter int ACC_LAT = 1,
  parameter int SCORE_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  otsu_sweep_ctrl_if.master   bus
);

  localparam logic [BIN_W-1:0] DRAIN_LAST = BIN_W'(ACC_LAT);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] t_q, t_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             acc_clear_q, acc_clear_d;
  logic             acc_valid_q, acc_valid_d;
  logic [BIN_W-1:0] acc_i_q, acc_i_d;
  logic [BIN_W-1:0] acc_thr_q, acc_thr_d;
  logic             eval_req_q, eval_req_d;
  logic [BIN_W-1:0] eval_thr_q, eval_thr_d;

  logic             score_take;

  assign score_take = (state_q == EVAL_WAIT) && bus.score_valid;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          t_d     = '0;
        end
      end
      CLEAR: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + BIN_W'(1);
        if (cnt_q == LAST_BIN) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // One cycle to present bin 255, then ACC_LAT cycles for the sums to settle.
        cnt_d = cnt_q + BIN_W'(1);
        if (cnt_q == DRAIN_LAST) begin
          state_d = EVAL_REQ;
        end
      end
      EVAL_REQ: begin
        state_d = EVAL_WAIT;
      end
      EVAL_WAIT: begin
        if (bus.score_valid) begin
          if (t_q == LAST_BIN) begin
            state_d = DONE;
          end else begin
            t_d     = t_q + BIN_W'(1);
            state_d = CLEAR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    busy_d      = is_busy_state(state_d);
    done_d      = (state_d == DONE);
    acc_clear_d = (state_d == CLEAR);
    eval_req_d  = (state_d == EVAL_REQ);
    eval_thr_d  = (state_d == EVAL_REQ) ? t_d : '0;

    // The feed trails the read by one cycle, matching the RAM's read latency.
    acc_valid_d = (state_q == SWEEP);
    acc_i_d     = (state_q == SWEEP) ? cnt_q : '0;
    acc_thr_d   = (state_q == SWEEP) ? t_q   : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_i_q     <= '0;
      acc_thr_q   <= '0;
      eval_req_q  <= 1'b0;
      eval_thr_q  <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      acc_clear_q <= acc_clear_d;
      acc_valid_q <= acc_valid_d;
      acc_i_q     <= acc_i_d;
      acc_thr_q   <= acc_thr_d;
      eval_req_q  <= eval_req_d;
      eval_thr_q  <= eval_thr_d;
    end
  end

  otsu_best_tracker #(
    .SCORE_W (SCORE_W)
  ) u_best (
    .clk            (clk),
    .reset          (reset),
    .load_en        (score_take),
    .first          (t_q == '0),
    .threshold      (t_q),
    .score          (bus.score),
    .best_threshold (bus.best_threshold),
    .best_score     (bus.best_score)
  );

  assign bus.hist_rd_en     = (state_q == SWEEP);
  assign bus.hist_addr      = (state_q == SWEEP) ? cnt_q : '0;

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.acc_clear      = acc_clear_q;
  assign bus.acc_valid      = acc_valid_q;
  assign bus.acc_i          = acc_i_q;
  // RAM data is already registered at its source; gate it so the bus idles at zero.
  assign bus.acc_n_i        = acc_valid_q ? bus.hist_data : '0;
  assign bus.acc_threshold  = acc_thr_q;
  assign bus.eval_req       = eval_req_q;
  assign bus.eval_threshold = eval_thr_q;

endmodule

// File: tb/tb_otsu_sweep_ctrl.sv
// Bench for otsu_sweep_ctrl: histogram RAM and evaluator models, feed scoreboard, reset scenarios.
module tb_otsu_sweep_ctrl;
  import otsu_pkg::*;

  localparam int PER_T = 261;

  logic clk;
  logic reset;

  otsu_sweep_ctrl_if #(.SCORE_W(64)) bus();

  otsu_sweep_ctrl #(.ACC_LAT(1), .SCORE_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  i;
    logic [31:0] n;
  } feed_t;

  feed_t       sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] hist [256];
  bit          parabola, delay_t3, eval_mute, stray_req, score_drv, fed_vld, last_rd;
  int          pending, pend_t, fed_addr, last_addr;

  function automatic logic [63:0] score_fn(int t);
    if (parabola) return 64'(t * (255 - t));
    return 64'd0;
  endfunction

  function automatic logic [141:0] outs_vec();
    return {bus.busy, bus.done, bus.acc_clear, bus.acc_valid, bus.eval_req, bus.hist_rd_en,
            bus.acc_i, bus.acc_n_i, bus.acc_threshold, bus.eval_threshold, bus.hist_addr,
            bus.best_threshold, bus.best_score};
  endfunction

  // One clock: RAM answers last cycle's read, evaluator answers after its delay, then sample.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    fed_vld  = last_rd;
    fed_addr = last_addr;
    if (last_rd) bus.hist_data = hist[last_addr];
    bus.score_valid = 1'b0;
    bus.score       = 64'd0;
    score_drv       = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        bus.score_valid = 1'b1;
        bus.score       = score_fn(pend_t);
        score_drv       = 1'b1;
      end
    end else if (stray_req) begin
      bus.score_valid = 1'b1;
      bus.score       = '1;
      stray_req       = 1'b0;
    end
    #1;
    last_rd   = bus.hist_rd_en;
    last_addr = int'(bus.hist_addr);
    if (bus.eval_req && !eval_mute) begin
      pend_t  = int'(bus.eval_threshold);
      pending = (delay_t3 && bus.eval_threshold == 8'd3) ? 10 : 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs_vec());
    end
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want 0", outs_vec());
    end
  endtask

  task automatic test_full_search();
    int  exp_t, vld_cnt, clr_cnt, s;
    bit  prev_clr, done_seen;
    feed_t f;
    for (int k = 0; k < 256; k++) hist[k] = 32'(k + 1);
    parabola = 1'b1; delay_t3 = 1'b1; eval_mute = 1'b0; pending = 0;
    sb.delete();
    exp_t = 0; done_seen = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    s = cyc;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.acc_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL first_cycle busy/clear: got %b%b want 11", bus.busy, bus.acc_clear);
    end
    clr_cnt  = int'(bus.acc_clear);
    prev_clr = bus.acc_clear;
    vld_cnt  = 0;
    for (int n = 0; n < 70000 && !done_seen; n++) begin
      tick();
      if (fed_vld && exp_t == 5) begin
        f.i = 8'(fed_addr);
        f.n = hist[fed_addr];
        sb.push_back(f);
      end
      if (bus.acc_valid) begin
        vld_cnt++;
        if (exp_t == 5) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL feed_t5 unexpected: got i=%0d n=%0d want none", bus.acc_i, bus.acc_n_i);
          end else begin
            f = sb.pop_front();
            if (bus.acc_i !== f.i || bus.acc_n_i !== f.n || bus.acc_threshold !== 8'd5) begin
              n_fail++;
              $display("FAIL feed_t5: got (%0d,%0d,t%0d) want (%0d,%0d,t5)",
                       bus.acc_i, bus.acc_n_i, bus.acc_threshold, f.i, f.n);
            end
          end
        end
      end
      if (bus.acc_clear) clr_cnt++;
      if (bus.hist_rd_en && bus.hist_addr == 8'd0) begin
        n_cmp++;
        if (prev_clr !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_before_sweep t=%0d: got %b want 1", exp_t, prev_clr);
        end
      end
      prev_clr = bus.acc_clear;
      if (bus.eval_req) begin
        n_cmp++;
        if (bus.eval_threshold !== 8'(exp_t) || vld_cnt != 256 || clr_cnt != 1) begin
          n_fail++;
          $display("FAIL per_threshold t=%0d: got thr=%0d vld=%0d clr=%0d want thr=%0d vld=256 clr=1",
                   exp_t, bus.eval_threshold, vld_cnt, clr_cnt, exp_t);
        end
        if (exp_t == 5) begin
          n_cmp++;
          if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL feed_t5 missing: got %0d left want 0", sb.size());
          end
        end
        vld_cnt = 0;
        clr_cnt = 0;
      end
      if (exp_t == 2 && bus.hist_rd_en && bus.hist_addr == 8'd100) stray_req = 1'b1;
      bus.start = (exp_t == 1 && bus.hist_rd_en && bus.hist_addr == 8'd50);
      if (score_drv) exp_t++;
      if (bus.done) begin
        done_seen = 1'b1;
        n_cmp++;
        if (cyc - s + 1 != 256 * PER_T + 1 + 9) begin
          n_fail++;
          $display("FAIL done_cycle: got %0d want %0d", cyc - s + 1, 256 * PER_T + 1 + 9);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || exp_t != 256) begin
          n_fail++;
          $display("FAIL done_state: got busy=%b scores=%0d want busy=0 scores=256", bus.busy, exp_t);
        end
        n_cmp++;
        if (bus.best_threshold !== 8'd127 || bus.best_score !== 64'd16256) begin
          n_fail++;
          $display("FAIL best_parabola: got %0d/%0d want 127/16256", bus.best_threshold, bus.best_score);
        end
        bus.start = 1'b1;
      end
    end
    n_cmp++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done want done");
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_no_restart();
    int dcnt, bcnt, ccnt;
    dcnt = 0; bcnt = 0; ccnt = 0;
    repeat (400) begin
      tick();
      dcnt += int'(bus.done);
      bcnt += int'(bus.busy);
      ccnt += int'(bus.acc_clear) + int'(bus.hist_rd_en);
    end
    n_cmp++;
    if (dcnt != 0 || bcnt != 0 || ccnt != 0) begin
      n_fail++;
      $display("FAIL no_restart: got done=%0d busy=%0d act=%0d want 0/0/0", dcnt, bcnt, ccnt);
    end
    n_cmp++;
    if (bus.best_threshold !== 8'd127 || bus.best_score !== 64'd16256) begin
      n_fail++;
      $display("FAIL best_held: got %0d/%0d want 127/16256", bus.best_threshold, bus.best_score);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int exp_t;
    bit reached, seen_feed, got_eval;
    parabola = 1'b1; delay_t3 = 1'b0; pending = 0;
    exp_t = 0; reached = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 12000 && !reached; n++) begin
      tick();
      if (score_drv) exp_t++;
      if (exp_t == 40 && bus.hist_rd_en && bus.hist_addr == 8'd128) reached = 1'b1;
    end
    n_cmp++;
    if (!reached || bus.best_threshold !== 8'd39 || bus.best_score !== 64'd8424) begin
      n_fail++;
      $display("FAIL best_at_t40: got reached=%b %0d/%0d want 1 39/8424",
               reached, bus.best_threshold, bus.best_score);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pending = 0;
    n_cmp++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: got %h want 0", outs_vec());
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.acc_clear !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: got clear=%b busy=%b want 1/1", bus.acc_clear, bus.busy);
    end
    seen_feed = 1'b0; got_eval = 1'b0;
    for (int n = 0; n < 400 && !got_eval; n++) begin
      tick();
      if (bus.acc_valid && !seen_feed) begin
        seen_feed = 1'b1;
        n_cmp++;
        if (bus.acc_threshold !== 8'd0 || bus.acc_i !== 8'd0) begin
          n_fail++;
          $display("FAIL restart_feed: got t=%0d i=%0d want 0/0", bus.acc_threshold, bus.acc_i);
        end
      end
      if (bus.eval_req) begin
        got_eval = 1'b1;
        n_cmp++;
        if (bus.eval_threshold !== 8'd0) begin
          n_fail++;
          $display("FAIL restart_eval_t: got %0d want 0", bus.eval_threshold);
        end
      end
    end
    n_cmp++;
    if (!got_eval) begin
      n_fail++;
      $display("FAIL restart_timeout: got no eval_req want eval_req");
    end
  endtask

  task automatic test_reset_eval_wait();
    bit got;
    eval_mute = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      tick();
      if (bus.eval_req) got = 1'b1;
    end
    tick();
    n_cmp++;
    if (!got || bus.busy !== 1'b1 || bus.eval_req !== 1'b0) begin
      n_fail++;
      $display("FAIL eval_wait_hold: got eval=%b busy=%b want 1/1", got, bus.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (outs_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_eval_wait: got %h want 0", outs_vec());
    end
    stray_req = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus.best_score !== 64'd0 || bus.busy !== 1'b0 || bus.acc_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL late_score_ignored: got score=%0d busy=%b want 0/0", bus.best_score, bus.busy);
    end
    eval_mute = 1'b0;
  endtask

  task automatic test_zero_scores();
    int exp_t;
    bit reached;
    parabola = 1'b0; pending = 0;
    for (int k = 0; k < 256; k++) hist[k] = 32'd0;
    exp_t = 0; reached = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 1200 && !reached; n++) begin
      tick();
      if (score_drv) exp_t++;
      if (exp_t == 3 && bus.acc_clear) reached = 1'b1;
    end
    n_cmp++;
    if (!reached || bus.best_threshold !== 8'd0 || bus.best_score !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_score_ties: got reached=%b %0d/%0d want 1 0/0",
               reached, bus.best_threshold, bus.best_score);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.hist_data = 32'd0;
    bus.score_valid = 1'b0;
    bus.score = 64'd0;
    parabola = 1'b0; delay_t3 = 1'b0; eval_mute = 1'b0; stray_req = 1'b0;
    score_drv = 1'b0; fed_vld = 1'b0; last_rd = 1'b0;
    pending = 0; pend_t = 0; fed_addr = 0; last_addr = 0;
    for (int k = 0; k < 256; k++) hist[k] = 32'd0;

    test_reset();
    test_full_search();
    test_no_restart();
    test_reset_mid_sweep();
    test_reset_eval_wait();
    test_zero_scores();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/otsu_sweep_ctrl.md
OTSU_SWEEP_CTRL -- requirements
Module: otsu_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_LAT, default 1: cycles from acc_valid to an updated accumulator result (range 1..4).
REQ-002 SHALL have parameter SCORE_W, default 64: width of the variance score.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have: start  in  1  single-cycle request to begin a full threshold search.
REQ-006 SHALL have: busy  out  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have: done  out  1  one-cycle pulse when the search completes.
REQ-008 SHALL have: best_threshold  out  8  threshold with the maximum score; held until next start.
REQ-009 SHALL have: best_score  out  SCORE_W  score of best_threshold.
REQ-010 SHALL have: hist_rd_en, hist_addr  out  1, 8  histogram RAM read port.
REQ-011 SHALL have: hist_data  in  32  bin count returned with 1-cycle read latency.
REQ-012 SHALL have: acc_clear  out  1  clears the external fg/bg sum and count accumulators.
REQ-013 SHALL have: acc_valid, acc_i, acc_n_i, acc_threshold  out  1, 8, 32, 8  accumulator feed.
REQ-014 SHALL have: eval_req, eval_threshold  out  1, 8  request to the variance evaluator.
REQ-015 SHALL have: score_valid, score  in  1, SCORE_W  evaluator result.

Function
REQ-016 SHALL implement states IDLE, CLEAR, SWEEP, DRAIN, EVAL_REQ, EVAL_WAIT, DONE.
REQ-017 IDLE: start=1 -> CLEAR with t=0; start in any other state SHALL be ignored.
REQ-018 CLEAR: acc_clear=1 for exactly one cycle, then SWEEP.
REQ-019 SWEEP: 256 cycles, hist_rd_en=1, hist_addr=0..255 ascending, then DRAIN.
REQ-020 The feed SHALL lag the read by one cycle: acc_valid=1, acc_i=previous hist_addr, acc_n_i=hist_data, acc_threshold=t.
REQ-021 DRAIN: 1+ACC_LAT cycles, with acc_valid high only in the first cycle (bin 255), then EVAL_REQ.
REQ-022 EVAL_REQ: eval_req=1 and eval_threshold=t for one cycle, then EVAL_WAIT.
REQ-023 EVAL_WAIT: hold until score_valid=1, with no timeout. score_valid in any other state SHALL be ignored.
REQ-024 On accepted score: if t==0 or score > best_score (unsigned, strict), load best_score=score and best_threshold=t. Ties SHALL keep the lower threshold.
REQ-025 After the score: t==255 -> DONE; otherwise t=t+1 -> CLEAR. t SHALL NOT wrap.
REQ-026 DONE: done=1 for one cycle, busy=0, then IDLE. start in the DONE cycle SHALL be ignored.
REQ-027 With ACC_LAT=1 and score_valid one cycle after eval_req, each threshold SHALL take 261 cycles.
REQ-028 Timing: start sampled at cycle 0 -> done at cycle 66817.
REQ-029 acc_valid, acc_clear, eval_req and hist_rd_en SHALL be 0 outside the states named above.
REQ-030 Outputs SHALL be registered except hist_addr/hist_rd_en, which may be state-decoded.

Reset
REQ-031 reset SHALL force IDLE from any state within one cycle, including mid-SWEEP and mid-EVAL_WAIT.
REQ-032 Reset SHALL clear all outputs: busy, done, acc_*, eval_*, hist_rd_en, best_threshold and best_score to 0.
REQ-033 An in-flight score arriving after reset SHALL be ignored.

Structure
REQ-034 Package otsu_pkg SHALL hold NUM_BINS=256, BIN_W=8, COUNT_W=32 and the state enum.
REQ-035 The datapath SHALL be a single flat module. An optional sub-module otsu_best_tracker SHALL own the compare/load of REQ-024.

Verification
REQ-036 Histogram all-zero, evaluator returns score=0 every time -> done at cycle 66817, best_threshold=0, best_score=0.
REQ-037 Evaluator returns score=t*(255-t) -> best_threshold=127, best_score=16256 (tie with 128 keeps 127).
REQ-038 hist[k]=k+1 -> for t=5, acc_i/acc_n_i sequence (0,1)..(255,256), 256 acc_valid pulses, and acc_clear precedes each sweep.
REQ-039 Evaluator delays score_valid 10 cycles at t=3, and a stray score_valid is injected during SWEEP -> FSM waits, the stray pulse is ignored, and the result is unchanged.
REQ-040 Reset asserted at t=40 mid-SWEEP, then start reissued -> all outputs 0 in the cycle after reset, and the full search restarts from t=0.
REQ-041 start pulsed while busy and in the DONE cycle -> no restart; exactly one done pulse.
